// File: rtl/chain_code_tracer.sv
// chain_code_tracer
// Raster-scans a binary image held in an external single-port RAM for the
// first foreground pixel, then traces that object's outer boundary with
// 8-connected Moore tracing and streams Freeman direction codes to a
// valid/ready consumer. One trace per rising edge of start.
//
// Ports:
//   clk_1       system clock, all logic on the rising edge
//   reset       synchronous active-low reset
//   start       trace request, rising edge honoured only while idle
//   pix_rd_en   RAM read strobe
//   pix_addr    RAM address, y*WIDTH + x
//   pix_data    pixel value (1 = foreground), valid the cycle after pix_rd_en
//   code_valid  code_data holds a valid Freeman code
//   code_data   Freeman code 0=E 1=NE 2=N 3=NW 4=W 5=SW 6=S 7=SE (N is y-1)
//   code_ready  consumer accepts the code when code_valid & code_ready
//   busy        high from trace start until done
//   done        one-cycle pulse at end of trace
//   no_object   image had no foreground; held until the next start
//   code_count  codes accepted this trace; held until the next start
module chain_code_tracer #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int AW     = 6
) (
  input  logic          clk_1,
  input  logic          reset,
  input  logic          start,
  output logic          pix_rd_en,
  output logic [AW-1:0] pix_addr,
  input  logic          pix_data,
  output logic          code_valid,
  output logic [2:0]    code_data,
  input  logic          code_ready,
  output logic          busy,
  output logic          done,
  output logic          no_object,
  output logic [AW:0]   code_count
);

  // Coordinates carry a sign bit plus one spare bit so neighbour candidates
  // one step outside the image are representable.
  localparam int MAXD = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  localparam int CW   = $clog2(MAXD) + 2;

  localparam logic signed [CW-1:0] W_S    = CW'(WIDTH);
  localparam logic signed [CW-1:0] H_S    = CW'(HEIGHT);
  localparam logic signed [CW-1:0] W_LAST = CW'(WIDTH - 1);
  localparam logic signed [CW-1:0] H_LAST = CW'(HEIGHT - 1);
  localparam logic signed [CW-1:0] P1     = CW'(1);
  localparam logic signed [CW-1:0] M1     = CW'(-1);
  localparam logic signed [CW-1:0] Z0     = '0;

  typedef enum logic [2:0] {
    IDLE, SCAN_RD, SCAN_CHK, NB_RD, NB_CHK, EMIT, FIN
  } state_t;

  state_t                state_reg, state_next;
  logic signed [CW-1:0]  cur_x_reg, cur_x_next, cur_y_reg, cur_y_next;
  logic signed [CW-1:0]  s_x_reg, s_x_next, s_y_reg, s_y_next;
  logic [2:0]            d_reg, d_next;
  logic [2:0]            k_reg, k_next;
  logic                  no_object_reg, no_object_next;
  logic [AW:0]           count_reg, count_next;
  logic                  start_d_reg;

  logic                  start_edge;
  logic [2:0]            start_dir, cand_dir;
  logic signed [CW-1:0]  dx, dy, cand_x, cand_y;
  logic                  cand_oob, at_last, at_start;

  function automatic logic [AW-1:0] addr_of(input logic [CW-1:0] xx,
                                            input logic [CW-1:0] yy);
    logic [31:0] t;
    t = 32'(yy) * 32'(WIDTH) + 32'(xx);
    return t[AW-1:0];
  endfunction

  assign start_edge = start & ~start_d_reg;

  // Moore search begins just past the backtrack direction: one step back
  // for axial moves, two steps back for diagonal moves.
  assign start_dir = d_reg[0] ? (d_reg + 3'd6) : (d_reg + 3'd7);
  assign cand_dir  = start_dir + k_reg;

  always_comb begin
    dx = Z0;
    dy = Z0;
    case (cand_dir)
      3'd0: begin dx = P1; dy = Z0; end
      3'd1: begin dx = P1; dy = M1; end
      3'd2: begin dx = Z0; dy = M1; end
      3'd3: begin dx = M1; dy = M1; end
      3'd4: begin dx = M1; dy = Z0; end
      3'd5: begin dx = M1; dy = P1; end
      3'd6: begin dx = Z0; dy = P1; end
      3'd7: begin dx = P1; dy = P1; end
    endcase
  end

  assign cand_x   = cur_x_reg + dx;
  assign cand_y   = cur_y_reg + dy;
  assign cand_oob = cand_x[CW-1] | cand_y[CW-1] | (cand_x >= W_S) | (cand_y >= H_S);
  assign at_last  = (cur_x_reg == W_LAST) && (cur_y_reg == H_LAST);
  assign at_start = (cur_x_reg == s_x_reg) && (cur_y_reg == s_y_reg);

  assign no_object  = no_object_reg;
  assign code_count = count_reg;

  always_comb begin
    state_next     = state_reg;
    cur_x_next     = cur_x_reg;
    cur_y_next     = cur_y_reg;
    s_x_next       = s_x_reg;
    s_y_next       = s_y_reg;
    d_next         = d_reg;
    k_next         = k_reg;
    no_object_next = no_object_reg;
    count_next     = count_reg;
    pix_rd_en      = 1'b0;
    pix_addr       = '0;
    code_valid     = 1'b0;
    code_data      = 3'd0;
    busy           = 1'b0;
    done           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          count_next     = '0;
          no_object_next = 1'b0;
          cur_x_next     = Z0;
          cur_y_next     = Z0;
          state_next     = SCAN_RD;
        end
      end
      SCAN_RD: begin
        busy       = 1'b1;
        pix_rd_en  = 1'b1;
        pix_addr   = addr_of(cur_x_reg, cur_y_reg);
        state_next = SCAN_CHK;
      end
      SCAN_CHK: begin
        busy = 1'b1;
        if (pix_data) begin
          s_x_next   = cur_x_reg;
          s_y_next   = cur_y_reg;
          d_next     = 3'd7;
          k_next     = 3'd0;
          state_next = NB_RD;
        end else if (at_last) begin
          no_object_next = 1'b1;
          state_next     = FIN;
        end else begin
          if (cur_x_reg == W_LAST) begin
            cur_x_next = Z0;
            cur_y_next = cur_y_reg + P1;
          end else begin
            cur_x_next = cur_x_reg + P1;
          end
          state_next = SCAN_RD;
        end
      end
      NB_RD: begin
        busy = 1'b1;
        if (cand_oob) begin
          // Off-image neighbours are background; decide without a read.
          if (k_reg == 3'd7) state_next = FIN;
          else               k_next     = k_reg + 3'd1;
        end else begin
          pix_rd_en  = 1'b1;
          pix_addr   = addr_of(cand_x, cand_y);
          state_next = NB_CHK;
        end
      end
      NB_CHK: begin
        busy = 1'b1;
        if (pix_data) begin
          d_next     = cand_dir;
          cur_x_next = cand_x;
          cur_y_next = cand_y;
          state_next = EMIT;
        end else if (k_reg == 3'd7) begin
          state_next = FIN;
        end else begin
          k_next     = k_reg + 3'd1;
          state_next = NB_RD;
        end
      end
      EMIT: begin
        busy       = 1'b1;
        code_valid = 1'b1;
        code_data  = d_reg;
        if (code_ready) begin
          count_next = count_reg + {{AW{1'b0}}, 1'b1};
          k_next     = 3'd0;
          state_next = at_start ? FIN : NB_RD;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cur_x_reg     <= '0;
      cur_y_reg     <= '0;
      s_x_reg       <= '0;
      s_y_reg       <= '0;
      d_reg         <= '0;
      k_reg         <= '0;
      no_object_reg <= 1'b0;
      count_reg     <= '0;
      start_d_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_x_reg     <= cur_x_next;
      cur_y_reg     <= cur_y_next;
      s_x_reg       <= s_x_next;
      s_y_reg       <= s_y_next;
      d_reg         <= d_next;
      k_reg         <= k_next;
      no_object_reg <= no_object_next;
      count_reg     <= count_next;
      start_d_reg   <= start;
    end
  end

endmodule

// File: tb/tb_chain_code_tracer.sv
// Directed testbench for chain_code_tracer: a behavioural 8x8 image RAM with
// registered read, monitors logging read addresses and accepted codes, and
// one task per scenario comparing against hand-derived expectations.
module tb_chain_code_tracer;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 8;
  localparam int AW     = 6;

  logic          clk_1 = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          pix_rd_en;
  logic [AW-1:0] pix_addr;
  logic          pix_data = 1'b0;
  logic          code_valid;
  logic [2:0]    code_data;
  logic          code_ready = 1'b1;
  logic          busy;
  logic          done;
  logic          no_object;
  logic [AW:0]   code_count;

  logic          mem [0:WIDTH*HEIGHT-1];
  logic [AW-1:0] rd_log[$];
  logic [2:0]    code_log[$];
  bit            valid_seen;
  int            checks = 0;
  int            errors = 0;

  chain_code_tracer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) dut (
    .clk_1(clk_1), .reset(reset), .start(start),
    .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_data(pix_data),
    .code_valid(code_valid), .code_data(code_data), .code_ready(code_ready),
    .busy(busy), .done(done), .no_object(no_object), .code_count(code_count)
  );

  always #5 clk_1 = ~clk_1;

  always @(posedge clk_1) if (pix_rd_en) pix_data <= mem[pix_addr];

  always @(negedge clk_1) begin
    if (pix_rd_en) rd_log.push_back(pix_addr);
    if (code_valid) valid_seen = 1'b1;
    if (code_valid && code_ready) begin
      code_log.push_back(code_data);
      $display("code accepted: %0d (codes this trace %0d)", code_data, code_log.size());
    end
  end

  task automatic clear_image();
    for (int i = 0; i < WIDTH*HEIGHT; i++) mem[i] = 1'b0;
  endtask

  task automatic set_px(input int x, input int y);
    mem[y*WIDTH + x] = 1'b1;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    code_log.delete();
    valid_seen = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk_1); #1 start = 1'b1;
    @(posedge clk_1); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_1);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic get_codes4(output logic [11:0] v);
    v = '0;
    for (int i = 0; i < 4; i++)
      v = {v[8:0], (i < code_log.size()) ? code_log[i] : 3'd0};
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    repeat (3) @(posedge clk_1);
    @(negedge clk_1);
    outs = {pix_rd_en, pix_addr, code_valid, code_data, busy, done, no_object, code_count};
    checks++;
    if (outs !== 18'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    @(posedge clk_1); #1 reset = 1'b1;
    repeat (3) @(negedge clk_1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start busy got %b want 0", busy); end
  endtask

  task automatic test_empty_image();
    bit ok; int bad;
    clear_image(); clear_logs(); code_ready = 1'b1;
    do_start();
    wait_done(500, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL empty_done got %b want 1", ok); end
    checks++;
    if (no_object !== 1'b1) begin errors++; $display("FAIL empty_no_object got %b want 1", no_object); end
    checks++;
    if (code_count !== '0) begin errors++; $display("FAIL empty_count got %0d want 0", code_count); end
    checks++;
    if (rd_log.size() != 64) begin errors++; $display("FAIL empty_reads got %0d want 64", rd_log.size()); end
    bad = 0;
    for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] !== AW'(i)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL empty_addr_order got %0d out-of-order want 0", bad); end
    checks++;
    if (valid_seen !== 1'b0) begin errors++; $display("FAIL empty_valid got %b want 0", valid_seen); end
  endtask

  task automatic test_single_pixel();
    bit ok;
    clear_image(); set_px(3, 2); clear_logs(); code_ready = 1'b1;
    do_start();
    wait_done(500, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", ok); end
    checks++;
    if (no_object !== 1'b0) begin errors++; $display("FAIL single_no_object got %b want 0", no_object); end
    checks++;
    if (code_count !== '0 || code_log.size() != 0) begin
      errors++; $display("FAIL single_codes got count %0d log %0d want 0", code_count, code_log.size());
    end
    // 20 scan reads (addresses 0..19) plus 8 in-bounds neighbour reads
    checks++;
    if (rd_log.size() != 28) begin errors++; $display("FAIL single_reads got %0d want 28", rd_log.size()); end
    @(negedge clk_1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL single_after_done got busy %b done %b want 0 0", busy, done);
    end
  endtask

  task automatic test_square();
    bit ok; logic [11:0] v;
    clear_image(); set_px(2, 2); set_px(3, 2); set_px(2, 3); set_px(3, 3);
    clear_logs(); code_ready = 1'b1;
    do_start();
    wait_done(500, ok);
    get_codes4(v);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL square_done got %b want 1", ok); end
    checks++;
    if (code_log.size() != 4 || v !== {3'd6, 3'd0, 3'd2, 3'd4}) begin
      errors++; $display("FAIL square_codes got n=%0d %o want n=4 6024", code_log.size(), v);
    end
    checks++;
    if (code_count !== 7'd4) begin errors++; $display("FAIL square_count got %0d want 4", code_count); end
    checks++;
    if (no_object !== 1'b0) begin errors++; $display("FAIL square_no_object got %b want 0", no_object); end
  endtask

  task automatic test_edge_line();
    bit ok; logic [11:0] v; int bad;
    logic [AW-1:0] exp_rd [14];
    exp_rd = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd12, 6'd13, 6'd14, 6'd6, 6'd15, 6'd7, 6'd6, 6'd5};
    clear_image(); set_px(5, 0); set_px(6, 0); set_px(7, 0);
    clear_logs(); code_ready = 1'b1;
    do_start();
    wait_done(500, ok);
    get_codes4(v);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL line_done got %b want 1", ok); end
    checks++;
    if (code_log.size() != 4 || v !== {3'd0, 3'd0, 3'd4, 3'd4}) begin
      errors++; $display("FAIL line_codes got n=%0d %o want n=4 0044", code_log.size(), v);
    end
    checks++;
    if (code_count !== 7'd4) begin errors++; $display("FAIL line_count got %0d want 4", code_count); end
    bad = (rd_log.size() != 14) ? 1 : 0;
    for (int i = 0; i < 14 && i < rd_log.size(); i++) if (rd_log[i] !== exp_rd[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL line_reads got %0d reads %0d wrong want 14 exact", rd_log.size(), bad);
    end
  endtask

  task automatic test_backpressure();
    bit ok; bit found; logic [11:0] v;
    clear_image(); set_px(2, 2); set_px(3, 2); set_px(2, 3); set_px(3, 3);
    clear_logs(); code_ready = 1'b0;
    do_start();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_1);
      if (code_valid) begin found = 1'b1; break; end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL stall_first_valid got %b want 1", found); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk_1);
      checks++;
      if (code_valid !== 1'b1 || code_data !== 3'd6) begin
        errors++; $display("FAIL stall_hold cycle %0d got valid %b data %0d want 1 6", i, code_valid, code_data);
      end
    end
    code_ready = 1'b1;
    wait_done(500, ok);
    get_codes4(v);
    checks++;
    if (ok !== 1'b1 || code_log.size() != 4 || v !== {3'd6, 3'd0, 3'd2, 3'd4}) begin
      errors++; $display("FAIL stall_codes got done %b n=%0d %o want 1 n=4 6024", ok, code_log.size(), v);
    end
    checks++;
    if (code_count !== 7'd4) begin errors++; $display("FAIL stall_count got %0d want 4", code_count); end
  endtask

  task automatic test_reset_mid_trace();
    bit ok; bit found; logic [11:0] v; logic [17:0] outs;
    clear_logs(); code_ready = 1'b1;
    do_start();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_1);
      if (code_count == 7'd2) begin found = 1'b1; break; end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL midreset_progress got %b want 1", found); end
    reset = 1'b0;
    @(posedge clk_1); #1 reset = 1'b1;
    @(negedge clk_1);
    outs = {pix_rd_en, pix_addr, code_valid, code_data, busy, done, no_object, code_count};
    checks++;
    if (outs !== 18'd0) begin errors++; $display("FAIL midreset_outputs got %h want 0", outs); end
    clear_logs();
    do_start();
    wait_done(500, ok);
    get_codes4(v);
    checks++;
    if (ok !== 1'b1 || code_log.size() != 4 || v !== {3'd6, 3'd0, 3'd2, 3'd4}) begin
      errors++; $display("FAIL midreset_codes got done %b n=%0d %o want 1 n=4 6024", ok, code_log.size(), v);
    end
    checks++;
    if (code_count !== 7'd4) begin errors++; $display("FAIL midreset_count got %0d want 4", code_count); end
  endtask

  initial begin
    test_reset();
    test_empty_image();
    test_single_pixel();
    test_square();
    test_edge_line();
    test_backpressure();
    test_reset_mid_trace();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
